// File: rtl/csr_ext_acc_initiator.sv
`default_nettype none
// ============================================================================
// Module  : csr_ext_acc_initiator
// Brief   : valid/ready command stream to single-pulse CSR external access,
//           with bounded ack timeout and valid/ready response.
// Revision: 1.0
// ============================================================================
module csr_ext_acc_initiator #(
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int BYTE_ADDR_BIT_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 16
) (
  input  logic                           i_clk,
  input  logic                           i_async_rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic                           i_cmd_is_wr,
  input  logic [BYTE_ADDR_BIT_WIDTH-1:0] i_cmd_byte_addr,
  input  logic [WORD_BIT_WIDTH-1:0]      i_cmd_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]      i_cmd_wr_bit_en,
  output logic                           o_acc_req,
  output logic                           o_acc_req_is_wr,
  output logic [BYTE_ADDR_BIT_WIDTH-1:0] o_byte_addr,
  output logic [WORD_BIT_WIDTH-1:0]      o_wr_data,
  output logic [WORD_BIT_WIDTH-1:0]      o_wr_bit_en,
  input  logic                           i_rd_ack,
  input  logic [WORD_BIT_WIDTH-1:0]      i_rd_data,
  input  logic                           i_wr_ack,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic                           o_rsp_is_wr,
  output logic [WORD_BIT_WIDTH-1:0]      o_rsp_rd_data,
  output logic                           o_rsp_err,
  output logic                           o_proto_err
);

  // A disabled timeout still keeps a 1-bit saturating counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t                         state_q;
  logic                           rst_meta_q;
  logic                           rst_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               cnt_d;
  logic                           cmd_ready_q;
  logic                           acc_req_q;
  logic                           req_is_wr_q;
  logic [BYTE_ADDR_BIT_WIDTH-1:0] byte_addr_q;
  logic [WORD_BIT_WIDTH-1:0]      wr_data_q;
  logic [WORD_BIT_WIDTH-1:0]      wr_bit_en_q;
  logic                           rsp_valid_q;
  logic                           rsp_is_wr_q;
  logic [WORD_BIT_WIDTH-1:0]      rsp_rd_data_q;
  logic                           rsp_err_q;
  logic                           proto_err_q;

  logic w_any_ack;
  logic w_match_ack;
  logic w_wrong_ack;
  logic w_proto_hit;
  logic w_timeout;

  // Reset asserts asynchronously and is released on a clock edge.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  assign w_any_ack   = i_rd_ack | i_wr_ack;
  assign w_match_ack = req_is_wr_q ? i_wr_ack : i_rd_ack;
  assign w_wrong_ack = req_is_wr_q ? i_rd_ack : i_wr_ack;
  assign w_proto_hit = (i_rd_ack & i_wr_ack)
                     | (w_any_ack & (state_q != S_WAIT))
                     | (w_wrong_ack & (state_q == S_WAIT));

  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYCLES - 1);
      assign w_timeout = (cnt_q == c_last);
    end else begin : g_no_tmo
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge rst_q) begin
    if (rst_q) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      acc_req_q     <= 1'b0;
      req_is_wr_q   <= 1'b0;
      byte_addr_q   <= '0;
      wr_data_q     <= '0;
      wr_bit_en_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_is_wr_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_err_q     <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      if (w_proto_hit) begin
        proto_err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (i_cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            acc_req_q   <= 1'b1;
            req_is_wr_q <= i_cmd_is_wr;
            byte_addr_q <= i_cmd_byte_addr;
            wr_data_q   <= i_cmd_wr_data;
            wr_bit_en_q <= i_cmd_wr_bit_en;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          acc_req_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          // A matching ack in the final allowed cycle beats the timeout.
          if (w_match_ack) begin
            rsp_valid_q   <= 1'b1;
            rsp_is_wr_q   <= req_is_wr_q;
            rsp_rd_data_q <= req_is_wr_q ? '0 : i_rd_data;
            rsp_err_q     <= 1'b0;
            state_q       <= S_RSP;
          end else if (w_timeout) begin
            rsp_valid_q   <= 1'b1;
            rsp_is_wr_q   <= req_is_wr_q;
            rsp_rd_data_q <= '0;
            rsp_err_q     <= 1'b1;
            state_q       <= S_RSP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_acc_req       = acc_req_q;
  assign o_acc_req_is_wr = req_is_wr_q;
  assign o_byte_addr     = byte_addr_q;
  assign o_wr_data       = wr_data_q;
  assign o_wr_bit_en     = wr_bit_en_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_is_wr     = rsp_is_wr_q;
  assign o_rsp_rd_data   = rsp_rd_data_q;
  assign o_rsp_err       = rsp_err_q;
  assign o_proto_err     = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_ext_acc_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_csr_ext_acc_initiator
// Brief   : self-checking bench for csr_ext_acc_initiator (TIMEOUT_CYCLES=4).
// Revision: 1.0
// ============================================================================
module tb_csr_ext_acc_initiator;
  localparam int W = 32;
  localparam int A = 8;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         i_async_rst;
  logic         i_cmd_valid, o_cmd_ready, i_cmd_is_wr;
  logic [A-1:0] i_cmd_byte_addr;
  logic [W-1:0] i_cmd_wr_data, i_cmd_wr_bit_en;
  logic         o_acc_req, o_acc_req_is_wr;
  logic [A-1:0] o_byte_addr;
  logic [W-1:0] o_wr_data, o_wr_bit_en;
  logic         i_rd_ack, i_wr_ack;
  logic [W-1:0] i_rd_data;
  logic         o_rsp_valid, i_rsp_ready, o_rsp_is_wr;
  logic [W-1:0] o_rsp_rd_data;
  logic         o_rsp_err, o_proto_err;

  int n_pass  = 0;
  int n_total = 0;

  int                 req_cnt, req_cyc, rsp_cyc;
  logic [1+A+2*W-1:0] req_flds;
  logic [W+1:0]       rsp_flds;
  logic               unstable, rdy_during, rdy_after;

  always #5 clk = ~clk;

  csr_ext_acc_initiator #(
    .WORD_BIT_WIDTH      (W),
    .BYTE_ADDR_BIT_WIDTH (A),
    .TIMEOUT_CYCLES      (T)
  ) dut (
    .i_clk           (clk),
    .i_async_rst     (i_async_rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_is_wr     (i_cmd_is_wr),
    .i_cmd_byte_addr (i_cmd_byte_addr),
    .i_cmd_wr_data   (i_cmd_wr_data),
    .i_cmd_wr_bit_en (i_cmd_wr_bit_en),
    .o_acc_req       (o_acc_req),
    .o_acc_req_is_wr (o_acc_req_is_wr),
    .o_byte_addr     (o_byte_addr),
    .o_wr_data       (o_wr_data),
    .o_wr_bit_en     (o_wr_bit_en),
    .i_rd_ack        (i_rd_ack),
    .i_rd_data       (i_rd_data),
    .i_wr_ack        (i_wr_ack),
    .o_rsp_valid     (o_rsp_valid),
    .i_rsp_ready     (i_rsp_ready),
    .o_rsp_is_wr     (o_rsp_is_wr),
    .o_rsp_rd_data   (o_rsp_rd_data),
    .o_rsp_err       (o_rsp_err),
    .o_proto_err     (o_proto_err)
  );

  function automatic logic [110:0] all_outs();
    return {o_cmd_ready, o_acc_req, o_acc_req_is_wr, o_byte_addr, o_wr_data, o_wr_bit_en,
            o_rsp_valid, o_rsp_is_wr, o_rsp_rd_data, o_rsp_err, o_proto_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one command and records what the DUT does; cycle 0 is the handshake cycle.
  task automatic do_txn(input logic is_wr, input logic [A-1:0] addr, input logic [W-1:0] wd,
                        input logic [W-1:0] ben, input int ack_at, input int wrong_at,
                        input logic [W-1:0] rd, input int stall);
    int  cyc, stall_left;
    bit  hs, done;
    req_cnt = 0; req_cyc = -1; rsp_cyc = -1; req_flds = '0; rsp_flds = '0;
    unstable = 1'b0; rdy_during = 1'b0; rdy_after = 1'b0;
    hs = 1'b0; done = 1'b0; stall_left = 0;
    for (int k = 0; k < 20 && o_cmd_ready !== 1'b1; k++) step();
    i_cmd_valid = 1'b1; i_cmd_is_wr = is_wr; i_cmd_byte_addr = addr;
    i_cmd_wr_data = wd; i_cmd_wr_bit_en = ben;
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
      i_cmd_valid = 1'b0;
      i_rd_ack = 1'b0; i_wr_ack = 1'b0; i_rd_data = $urandom;
      if (hs) begin
        rdy_after = o_cmd_ready;
        i_rsp_ready = 1'b0;
        done = 1'b1;
      end else begin
        if (o_acc_req === 1'b1) begin
          req_cnt++;
          if (req_cnt == 1) begin
            req_cyc  = cyc;
            req_flds = {o_acc_req_is_wr, o_byte_addr, o_wr_data, o_wr_bit_en};
          end
        end
        if (o_cmd_ready !== 1'b0) rdy_during = 1'b1;
        if (rsp_cyc < 0 && o_rsp_valid === 1'b1) begin
          rsp_cyc    = cyc;
          rsp_flds   = {o_rsp_is_wr, o_rsp_rd_data, o_rsp_err};
          stall_left = stall;
        end else if (rsp_cyc >= 0) begin
          if (o_rsp_valid !== 1'b1 || {o_rsp_is_wr, o_rsp_rd_data, o_rsp_err} !== rsp_flds)
            unstable = 1'b1;
        end
        if (rsp_cyc >= 0) begin
          if (stall_left == 0) begin
            i_rsp_ready = 1'b1;
            hs = 1'b1;
          end else begin
            i_rsp_ready = 1'b0;
            stall_left--;
          end
        end
        if (cyc == ack_at) begin
          if (is_wr) i_wr_ack = 1'b1;
          else begin i_rd_ack = 1'b1; i_rd_data = rd; end
        end
        if (cyc == wrong_at) begin
          if (is_wr) i_rd_ack = 1'b1;
          else i_wr_ack = 1'b1;
        end
      end
    end
    i_rd_ack = 1'b0; i_wr_ack = 1'b0; i_rsp_ready = 1'b0; i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_total++;
    if (all_outs() !== '0) $display("FAIL reset_hold: outs=%h want 0", all_outs());
    else n_pass++;
    @(posedge clk); #3 i_async_rst = 1'b0;
    repeat (5) step();
    n_total++;
    if ({o_cmd_ready, o_acc_req, o_rsp_valid, o_proto_err} !== 4'b1000)
      $display("FAIL reset_release: rdy/req/rsp/perr=%b want 1000",
               {o_cmd_ready, o_acc_req, o_rsp_valid, o_proto_err});
    else n_pass++;
  endtask

  task automatic test_write();
    do_txn(1'b1, 8'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 2, -1, '0, 0);
    n_total++;
    if (req_cnt !== 1 || req_cyc !== 1)
      $display("FAIL wr_req: cnt=%0d cyc=%0d want 1/1", req_cnt, req_cyc);
    else n_pass++;
    n_total++;
    if (req_flds !== {1'b1, 8'h10, 32'hDEADBEEF, 32'hFFFFFFFF})
      $display("FAIL wr_req_flds: got %h", req_flds);
    else n_pass++;
    n_total++;
    if (rsp_cyc !== 3 || rsp_flds !== {1'b1, 32'h0, 1'b0})
      $display("FAIL wr_rsp: cyc=%0d flds=%h want 3/%h", rsp_cyc, rsp_flds, {1'b1, 32'h0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_read();
    do_txn(1'b0, 8'h24, 32'h0, 32'h0, 3, -1, 32'h12345678, 0);
    n_total++;
    if (req_cnt !== 1 || req_flds[1+A+2*W-1 -: 1+A] !== {1'b0, 8'h24})
      $display("FAIL rd_req: cnt=%0d flds=%h", req_cnt, req_flds);
    else n_pass++;
    n_total++;
    if (rsp_cyc !== 4 || rsp_flds !== {1'b0, 32'h12345678, 1'b0})
      $display("FAIL rd_rsp: cyc=%0d flds=%h want 4/%h", rsp_cyc, rsp_flds,
               {1'b0, 32'h12345678, 1'b0});
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    do_txn(1'b0, 8'h3C, 32'h0, 32'h0, 2, -1, 32'hA5A5_0F0F, 5);
    n_total++;
    if (rsp_cyc !== 3 || rsp_flds !== {1'b0, 32'hA5A5_0F0F, 1'b0})
      $display("FAIL bp_rsp: cyc=%0d flds=%h", rsp_cyc, rsp_flds);
    else n_pass++;
    n_total++;
    if (unstable !== 1'b0 || rdy_during !== 1'b0)
      $display("FAIL bp_stable: unstable=%b ready_during=%b want 0/0", unstable, rdy_during);
    else n_pass++;
    n_total++;
    if (rdy_after !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", rdy_after);
    else n_pass++;
  endtask

  task automatic test_random();
    logic         is_wr, err;
    logic [A-1:0] addr;
    logic [W-1:0] wd, ben, rd;
    int           ack_at, stall, exp_cyc;
    for (int i = 0; i < 16; i++) begin
      is_wr  = 1'($urandom_range(0, 1));
      addr   = 8'($urandom);
      wd     = $urandom; ben = $urandom; rd = $urandom;
      ack_at = ($urandom_range(0, 4) == 4) ? -1 : 2 + int'($urandom_range(0, T - 1));
      stall  = int'($urandom_range(0, 3));
      do_txn(is_wr, addr, wd, ben, ack_at, -1, rd, stall);
      // Ack counts only within the T-cycle window that starts at cycle 2.
      err     = (ack_at < 2) || (ack_at > 1 + T);
      exp_cyc = err ? 2 + T : ack_at + 1;
      n_total++;
      if (req_cnt !== 1 || req_cyc !== 1 || req_flds !== {is_wr, addr, wd, ben})
        $display("FAIL rnd%0d_req: cnt=%0d cyc=%0d flds=%h", i, req_cnt, req_cyc, req_flds);
      else n_pass++;
      n_total++;
      if (rsp_cyc !== exp_cyc)
        $display("FAIL rnd%0d_rsp_cyc: got %0d want %0d", i, rsp_cyc, exp_cyc);
      else n_pass++;
      n_total++;
      if (rsp_flds !== {is_wr, (is_wr || err) ? 32'h0 : rd, err})
        $display("FAIL rnd%0d_rsp_flds: got %h want %h", i, rsp_flds,
                 {is_wr, (is_wr || err) ? 32'h0 : rd, err});
      else n_pass++;
      n_total++;
      if ({unstable, rdy_during, rdy_after, o_proto_err} !== 4'b0010)
        $display("FAIL rnd%0d_hs: unst/rdy_dur/rdy_aft/perr=%b want 0010", i,
                 {unstable, rdy_during, rdy_after, o_proto_err});
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 8'h44, 32'h0, 32'h0, -1, -1, '0, 0);
    n_total++;
    if (rsp_cyc !== 2 + T || rsp_flds !== {1'b0, 32'h0, 1'b1})
      $display("FAIL tmo_rsp: cyc=%0d flds=%h want %0d/%h", rsp_cyc, rsp_flds, 2 + T,
               {1'b0, 32'h0, 1'b1});
    else n_pass++;
    n_total++;
    if (o_proto_err !== 1'b0) $display("FAIL tmo_perr_pre: got %b want 0", o_proto_err);
    else n_pass++;
    i_rd_ack = 1'b1;
    step();
    i_rd_ack = 1'b0;
    step();
    n_total++;
    if (o_proto_err !== 1'b1) $display("FAIL idle_ack_perr: got %b want 1", o_proto_err);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit seen;
    for (int k = 0; k < 20 && o_cmd_ready !== 1'b1; k++) step();
    i_cmd_valid = 1'b1; i_cmd_is_wr = 1'b1; i_cmd_byte_addr = 8'h5A;
    i_cmd_wr_data = 32'hCAFE_F00D; i_cmd_wr_bit_en = 32'h00FF_FF00;
    step();
    i_cmd_valid = 1'b0;
    step();
    step();
    n_total++;
    if ({o_byte_addr, o_proto_err} !== {8'h5A, 1'b1})
      $display("FAIL arst_pre: addr=%h perr=%b want 5a/1", o_byte_addr, o_proto_err);
    else n_pass++;
    #3 i_async_rst = 1'b1;
    #1;
    n_total++;
    if (all_outs() !== '0) $display("FAIL arst_immediate: outs=%h want 0", all_outs());
    else n_pass++;
    step();
    step();
    #3 i_async_rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_rsp_valid !== 1'b0 || o_acc_req !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if ({seen, o_cmd_ready, o_proto_err} !== 3'b010)
      $display("FAIL arst_after: spurious/rdy/perr=%b want 010", {seen, o_cmd_ready, o_proto_err});
    else n_pass++;
  endtask

  task automatic test_mismatch();
    n_total++;
    if (o_proto_err !== 1'b0) $display("FAIL mm_perr_pre: got %b want 0", o_proto_err);
    else n_pass++;
    do_txn(1'b1, 8'h70, 32'h1357_9BDF, 32'hFFFF_0000, 3, 2, '0, 0);
    n_total++;
    if (rsp_cyc !== 4 || rsp_flds !== {1'b1, 32'h0, 1'b0})
      $display("FAIL mm_rsp: cyc=%0d flds=%h want 4/%h", rsp_cyc, rsp_flds, {1'b1, 32'h0, 1'b0});
    else n_pass++;
    n_total++;
    if (o_proto_err !== 1'b1) $display("FAIL mm_perr: got %b want 1", o_proto_err);
    else n_pass++;
  endtask

  initial begin
    i_async_rst = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_is_wr = 1'b0; i_cmd_byte_addr = '0;
    i_cmd_wr_data = '0; i_cmd_wr_bit_en = '0;
    i_rd_ack = 1'b0; i_wr_ack = 1'b0; i_rd_data = '0; i_rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_pressure();
    test_random();
    test_timeout();
    test_async_reset();
    test_mismatch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_ext_acc_initiator.md
Name: csr_ext_acc_initiator

Overview:
- Master for the CSR external-block access protocol (acc_req / acc_req_is_wr / byte_addr / wr_data / wr_bit_en out; rd_ack / rd_data / wr_ack in).
- Converts a valid/ready command stream, e.g. from a test sequencer or debug bus, into single-pulse CSR accesses.
- Waits for the matching ack with a bounded timeout and returns a valid/ready response carrying read data and an error flag.
- One outstanding access at a time.

Parameters:
- WORD_BIT_WIDTH, 32, data word width in bits; must be a power of 2 and ≥8.
- BYTE_ADDR_BIT_WIDTH, 8, byte address width.
- TIMEOUT_CYCLES, 16, WAIT cycles allowed before a timeout response; 0 disables the timeout (wait forever).

Ports:
- i_clk  in  1  clock.
- i_async_rst  in  1  asynchronous active-high reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command ready.
- i_cmd_is_wr  in  1  1: write, 0: read.
- i_cmd_byte_addr  in  BYTE_ADDR_BIT_WIDTH  byte address.
- i_cmd_wr_data  in  WORD_BIT_WIDTH  write data.
- i_cmd_wr_bit_en  in  WORD_BIT_WIDTH  write bit enable.
- o_acc_req  out  1  CSR access request pulse.
- o_acc_req_is_wr  out  1  request is write.
- o_byte_addr  out  BYTE_ADDR_BIT_WIDTH  request address.
- o_wr_data  out  WORD_BIT_WIDTH  request write data.
- o_wr_bit_en  out  WORD_BIT_WIDTH  request write bit enable.
- i_rd_ack  in  1  read acknowledge.
- i_rd_data  in  WORD_BIT_WIDTH  read data, valid with i_rd_ack.
- i_wr_ack  in  1  write acknowledge.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_is_wr  out  1  response belongs to a write.
- o_rsp_rd_data  out  WORD_BIT_WIDTH  captured read data; 0 for writes and on error.
- o_rsp_err  out  1  1: timeout.
- o_proto_err  out  1  sticky spurious/mismatched-ack flag.

Behaviour:
- Reset: async assert, synchronous deassert internally.
  - All outputs go to 0; state IDLE; timeout counter 0; o_proto_err 0.
  - Reset mid-access abandons it with no response. Acks arriving after reset release are spurious.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - o_cmd_ready=1 only in IDLE.
  - On i_cmd_valid && o_cmd_ready, register all cmd fields and go to REQ.
- REQ (exactly one cycle):
  - o_acc_req=1; o_acc_req_is_wr, o_byte_addr, o_wr_data and o_wr_bit_en driven from registered fields.
  - Next state WAIT; counter cleared.
  - The address fields and o_acc_req_is_wr hold their registered values until the next command is accepted.
  - o_acc_req is 0 in every other state.
- WAIT:
  - Matching ack is i_wr_ack for a write, i_rd_ack for a read.
  - On matching ack: capture i_rd_data (reads only) and go to RSP with err=0.
  - Counter increments each WAIT cycle without a matching ack.
  - If TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES WAIT cycles elapse without ack: go to RSP with err=1, rd_data=0.
  - A matching ack in the last allowed WAIT cycle wins over the timeout.
- RSP:
  - o_rsp_valid=1 with fields stable until i_rsp_ready.
  - On handshake go to IDLE. o_cmd_ready rises the following cycle; no cmd/rsp bypass.
- Latency: cmd handshake at cycle 0 → o_acc_req at cycle 1 → earliest ack at cycle 2 → o_rsp_valid at cycle 3. Each extra ack cycle adds 1.
- Timeout latency: no-ack response appears at cycle 2+TIMEOUT_CYCLES.
- o_proto_err sets and stays 1 until reset on any of:
  - any ack in IDLE, REQ or RSP;
  - the non-matching ack type in WAIT (ignored for completion);
  - i_rd_ack && i_wr_ack in the same cycle.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates; it never wraps.
- byte_addr is passed unmodified. Alignment is the slave's concern.

Test Plan:
- Write: cmd write addr 0x10, data 0xDEADBEEF, bit_en all-ones; wr_ack at cycle 2 → o_acc_req pulse at cycle 1 with those fields; rsp at cycle 3 with is_wr=1, rd_data=0, err=0.
- Read: cmd read addr 0x24; rd_ack with data 0x12345678 at cycle 3 → rsp at cycle 4 with rd_data=0x12345678, err=0.
- Timeout (TIMEOUT_CYCLES=4): read, no ack → rsp_valid at cycle 6, err=1, rd_data=0. A later rd_ack in IDLE → o_proto_err=1.
- Back-pressure: hold i_rsp_ready=0 for 5 cycles → rsp fields stable and o_cmd_ready=0 throughout; ready for the next cmd on the cycle after the handshake.
- Mismatch: write cmd answered first by rd_ack at cycle 2, then wr_ack at cycle 3 → o_proto_err=1; normal write rsp at cycle 4.
- Async reset asserted mid-WAIT between clock edges → all outputs 0 immediately; after release the FSM is in IDLE with o_cmd_ready=1 and no response is produced.
